// File: rtl/fifo_rd_arb_if.sv
// fifo_rd_arb_if: read-arbiter bus; master = arbiter (req/rempty/rdata in; rinc/gnt/dout/dout_valid/dout_id/busy out), slave = FIFO and consumers
interface fifo_rd_arb_if #(
  parameter int NREQ      = 4,
  parameter int DATA_SIZE = 8
);
  logic [NREQ-1:0]         req;
  logic                    rempty;
  logic [DATA_SIZE-1:0]    rdata;
  logic                    rinc;
  logic [NREQ-1:0]         gnt;
  logic [DATA_SIZE-1:0]    dout;
  logic                    dout_valid;
  logic [$clog2(NREQ)-1:0] dout_id;
  logic                    busy;
  modport master (input req, rempty, rdata, output rinc, gnt, dout, dout_valid, dout_id, busy);
  modport slave (output req, rempty, rdata, input rinc, gnt, dout, dout_valid, dout_id, busy);
endinterface

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin burst arbiter sharing one FIFO read port among NREQ consumers; ports rclk, rrst_n (async active-low), bus (fifo_rd_arb_if.master)
module fifo_rd_arb #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int NREQ      = 4,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 8
) (
  input logic           rclk,
  input logic           rrst_n,
  fifo_rd_arb_if.master bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(BURST + 1);
  localparam int SCW = $clog2(STALL_MAX + 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BURST - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(STALL_MAX - 1);
  localparam logic [SCW-1:0] S_SAT = SCW'(STALL_MAX);
  if (ADDR_SIZE < 1 || DATA_SIZE < 1 || NREQ < 2 || NREQ > 8 || BURST < 1 || BURST > 16 || STALL_MAX < 1 || STALL_MAX > 255) begin : g_bad_param
    $error("fifo_rd_arb: parameter out of range");
  end
  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_RELEASE} state_t;
  state_t          state, nxt;
  logic [IDW-1:0]  prio_ptr, owner, pick;
  logic [BCW-1:0]  burst_cnt;
  logic [SCW-1:0]  stall_cnt;
  logic            rinc, withdraw, done, stall_out;
  always_comb begin
    // descending scan so the lowest offset from prio_ptr wins
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[(int'(prio_ptr) + k) % NREQ]) pick = IDW'((int'(prio_ptr) + k) % NREQ);
    rinc = (state == ST_BURST) && !bus.rempty && bus.req[owner];
    withdraw = !bus.req[owner];
    done = rinc && (burst_cnt == B_LAST);
    stall_out = bus.rempty && (stall_cnt == S_LAST);
    nxt = state == ST_IDLE ? (|bus.req ? ST_BURST : ST_IDLE) :
          state == ST_BURST ? ((withdraw || done || stall_out) ? ST_RELEASE : ST_BURST) : ST_IDLE;
  end
  assign bus.rinc = rinc;
  assign bus.busy = state != ST_IDLE;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) state <= ST_IDLE;
    else state <= nxt;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      bus.gnt <= '0;
      bus.dout <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_id <= '0;
      prio_ptr <= '0;
      owner <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      bus.dout_valid <= rinc;
      if (rinc) begin
        bus.dout <= bus.rdata;
        bus.dout_id <= owner;
      end
      if (state == ST_IDLE && |bus.req) begin
        owner <= pick;
        bus.gnt <= NREQ'(1) << pick;
        burst_cnt <= '0;
        stall_cnt <= '0;
      end else if (state == ST_BURST) begin
        if (nxt != ST_BURST) bus.gnt <= '0;
        if (rinc) begin
          burst_cnt <= burst_cnt + 1'b1;
          stall_cnt <= '0;
        end else if (bus.rempty && stall_cnt != S_SAT) stall_cnt <= stall_cnt + 1'b1;
      end
      if (state == ST_RELEASE) prio_ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb_fifo_rd_arb: directed vector table plus hand sequences for round-robin, stall timeout and stall-clear
module tb_fifo_rd_arb;
  logic rclk, rrst_n;
  int checks = 0, errors = 0;
  fifo_rd_arb_if #(.NREQ(4), .DATA_SIZE(8)) bus ();
  fifo_rd_arb #(.ADDR_SIZE(4), .DATA_SIZE(8), .NREQ(4), .BURST(4), .STALL_MAX(8)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .bus(bus));
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;
  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rempty;
    logic [7:0] rdata;
    logic       e_rinc;
    logic [3:0] e_gnt;
    logic       e_dv;
    logic [7:0] e_dout;
    logic [1:0] e_id;
    logic       e_busy;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t v(logic r, logic [3:0] q, logic e, logic [7:0] d,
                             logic ri, logic [3:0] g, logic dv, logic [7:0] o, logic [1:0] id, logic b);
    vec_t t;
    t.rst_n = r; t.req = q; t.rempty = e; t.rdata = d;
    t.e_rinc = ri; t.e_gnt = g; t.e_dv = dv; t.e_dout = o; t.e_id = id; t.e_busy = b;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge rclk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    bus.req = '0;
    bus.rempty = 1'b1;
    #1;
    chk("reset_outputs", {bus.rinc, bus.gnt, bus.dout_valid, bus.dout, bus.dout_id, bus.busy}, '0);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask
  initial begin
    int n, reads, rinc_seen;
    logic [16:0] act, exp;
    rrst_n = 1'b0;
    bus.req = '0;
    bus.rempty = 1'b1;
    bus.rdata = '0;
    // single requester, 6 words, regrant for the remainder
    vecs.push_back(v(0, 4'h0, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(v(1, 4'h0, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(v(1, 4'h2, 0, 8'hA0, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(v(1, 4'h2, 0, 8'hA0, 1, 4'h2, 0, 8'h00, 0, 1));
    vecs.push_back(v(1, 4'h2, 0, 8'hA1, 1, 4'h2, 1, 8'hA0, 1, 1));
    vecs.push_back(v(1, 4'h2, 0, 8'hA2, 1, 4'h2, 1, 8'hA1, 1, 1));
    vecs.push_back(v(1, 4'h2, 0, 8'hA3, 1, 4'h2, 1, 8'hA2, 1, 1));
    vecs.push_back(v(1, 4'h2, 0, 8'hA4, 0, 4'h0, 1, 8'hA3, 1, 1));
    vecs.push_back(v(1, 4'h2, 0, 8'hA4, 0, 4'h0, 0, 8'hA3, 1, 0));
    vecs.push_back(v(1, 4'h2, 0, 8'hA4, 1, 4'h2, 0, 8'hA3, 1, 1));
    vecs.push_back(v(1, 4'h2, 0, 8'hA5, 1, 4'h2, 1, 8'hA4, 1, 1));
    vecs.push_back(v(1, 4'h2, 1, 8'hA5, 0, 4'h2, 1, 8'hA5, 1, 1));
    vecs.push_back(v(1, 4'h0, 1, 8'hA5, 0, 4'h2, 0, 8'hA5, 1, 1));
    vecs.push_back(v(1, 4'h0, 1, 8'hA5, 0, 4'h0, 0, 8'hA5, 1, 1));
    vecs.push_back(v(1, 4'h0, 1, 8'hA5, 0, 4'h0, 0, 8'hA5, 1, 0));
    // withdrawal by consumer 0 after 2 reads, then prio_ptr=1 shows in the next grant
    vecs.push_back(v(1, 4'h1, 0, 8'hB0, 0, 4'h0, 0, 8'hA5, 1, 0));
    vecs.push_back(v(1, 4'h1, 0, 8'hB0, 1, 4'h1, 0, 8'hA5, 1, 1));
    vecs.push_back(v(1, 4'h1, 0, 8'hB1, 1, 4'h1, 1, 8'hB0, 0, 1));
    vecs.push_back(v(1, 4'h0, 0, 8'hB2, 0, 4'h1, 1, 8'hB1, 0, 1));
    vecs.push_back(v(1, 4'h0, 0, 8'hB2, 0, 4'h0, 0, 8'hB1, 0, 1));
    vecs.push_back(v(1, 4'hF, 0, 8'hC0, 0, 4'h0, 0, 8'hB1, 0, 0));
    vecs.push_back(v(1, 4'hF, 0, 8'hC0, 1, 4'h2, 0, 8'hB1, 0, 1));
    vecs.push_back(v(1, 4'hF, 0, 8'hC1, 1, 4'h2, 1, 8'hC0, 1, 1));
    // reset after the second read: outputs drop at once, pending word discarded
    vecs.push_back(v(0, 4'hF, 0, 8'hC2, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(v(0, 4'h8, 0, 8'hC2, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(v(1, 4'h8, 0, 8'hD0, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(v(1, 4'h8, 0, 8'hD0, 1, 4'h8, 0, 8'h00, 0, 1));
    // empty after word 2, refill 3 cycles later, burst still totals 4
    vecs.push_back(v(1, 4'h8, 0, 8'hD1, 1, 4'h8, 1, 8'hD0, 3, 1));
    vecs.push_back(v(1, 4'h8, 1, 8'hD2, 0, 4'h8, 1, 8'hD1, 3, 1));
    vecs.push_back(v(1, 4'h8, 1, 8'hD2, 0, 4'h8, 0, 8'hD1, 3, 1));
    vecs.push_back(v(1, 4'h8, 1, 8'hD2, 0, 4'h8, 0, 8'hD1, 3, 1));
    vecs.push_back(v(1, 4'h8, 0, 8'hD2, 1, 4'h8, 0, 8'hD1, 3, 1));
    vecs.push_back(v(1, 4'h8, 0, 8'hD3, 1, 4'h8, 1, 8'hD2, 3, 1));
    vecs.push_back(v(1, 4'h8, 0, 8'hD4, 0, 4'h0, 1, 8'hD3, 3, 1));
    vecs.push_back(v(1, 4'h0, 0, 8'hD4, 0, 4'h0, 0, 8'hD3, 3, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge rclk);
      rrst_n = vecs[i].rst_n;
      bus.req = vecs[i].req;
      bus.rempty = vecs[i].rempty;
      bus.rdata = vecs[i].rdata;
      #1;
      act = {bus.rinc, bus.gnt, bus.dout_valid, bus.dout, bus.dout_id, bus.busy};
      exp = {vecs[i].e_rinc, vecs[i].e_gnt, vecs[i].e_dv, vecs[i].e_dout, vecs[i].e_id, vecs[i].e_busy};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec%0d {rinc,gnt,dv,dout,id,busy} actual=%h required=%h", i, act, exp);
      end
    end
    // round-robin with all requesters and a never-empty FIFO
    do_reset();
    bus.req = 4'hF;
    bus.rempty = 1'b0;
    bus.rdata = 8'h55;
    for (int b = 0; b < 5; b++) begin
      n = 0;
      do begin step(); n++; end while (bus.gnt == 4'h0 && n < 10);
      chk($sformatf("rr_gnt%0d", b), bus.gnt, 32'(4'h1 << (b % 4)));
      reads = 0;
      n = 0;
      while (bus.gnt != 4'h0 && n < 20) begin reads += int'(bus.rinc); step(); n++; end
      chk($sformatf("rr_reads%0d", b), reads, 4);
      chk($sformatf("rr_release%0d", b), {bus.busy, bus.rinc}, 2'b10);
    end
    // stall timeout on consumer 2 with an empty FIFO
    do_reset();
    bus.req = 4'h4;
    bus.rempty = 1'b1;
    n = 0;
    do begin step(); n++; end while (bus.gnt == 4'h0 && n < 10);
    chk("stall_gnt", bus.gnt, 4'h4);
    n = 0;
    rinc_seen = 0;
    while (bus.gnt != 4'h0 && n < 30) begin rinc_seen += int'(bus.rinc); step(); n++; end
    chk("stall_cycles", n, 8);
    chk("stall_no_rinc", rinc_seen, 0);
    chk("stall_release", {bus.busy, bus.rinc}, 2'b10);
    bus.req = 4'hF;
    n = 0;
    do begin step(); n++; end while (bus.gnt == 4'h0 && n < 10);
    chk("stall_prio3", bus.gnt, 4'h8);
    // a read after a partial stall restarts the stall timeout from zero
    bus.rempty = 1'b1;
    #1;
    chk("stallclr_rinc_off", bus.rinc, 0);
    repeat (4) step();
    bus.rempty = 1'b0;
    #1;
    chk("stallclr_rinc_on", bus.rinc, 1);
    step();
    bus.rempty = 1'b1;
    #1;
    n = 0;
    while (bus.gnt != 4'h0 && n < 30) begin step(); n++; end
    chk("stallclr_cycles", n, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
